// File: rtl/imsic_msi_tx_arb.sv
// Round-robin arbiter that serialises MSI front-end requests onto the IMSIC gate's level-pulse delivery path.
// Optional build macro IMSIC_MSI_TX_DROP_ZERO_EN: consume setipnum-0 requests without issuing a pulse.
module imsic_msi_tx_arb #(
  parameter int NR_REQ         = 2,
  parameter int MSI_INFO_WIDTH = 17,
  parameter int NR_SRC_WIDTH   = 5,
  parameter int HIGH_CYCLES    = 4,
  parameter int LOW_CYCLES     = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NR_REQ-1:0]                req_vld,
  input  logic [NR_REQ*MSI_INFO_WIDTH-1:0] req_info,
  output logic [NR_REQ-1:0]                req_rdy,
  output logic [MSI_INFO_WIDTH-1:0]        o_msi_info,
  output logic                             o_msi_info_vld,
  output logic                             busy
);

  localparam int PTR_W   = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
`ifdef IMSIC_MSI_TX_DROP_ZERO_EN
  localparam bit DROP_ZERO = 1'b1;
`else
  localparam bit DROP_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                    state, state_nxt;
  logic [PTR_W-1:0]          rr_ptr, rr_ptr_nxt, winner;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic                      found, accept, issue, zero_src;
  logic [MSI_INFO_WIDTH-1:0] win_info;

  // First requester at or after rr_ptr, wrapping modulo NR_REQ.
  always_comb begin
    logic [PTR_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      idx = PTR_W'((int'(rr_ptr) + i) % NR_REQ);
      if (!found && req_vld[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    win_info = '0;
    for (int r = 0; r < NR_REQ; r++) begin
      if (winner == PTR_W'(r)) win_info = req_info[r*MSI_INFO_WIDTH +: MSI_INFO_WIDTH];
    end
  end

  assign accept     = (state == IDLE) && found && rstn;
  assign zero_src   = (win_info[NR_SRC_WIDTH-1:0] == '0);
  assign issue      = accept && !(DROP_ZERO && zero_src);
  assign rr_ptr_nxt = PTR_W'((int'(winner) + 1) % NR_REQ);

  always_comb begin
    req_rdy = '0;
    if (accept) req_rdy[winner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (issue) begin
          state_nxt = HIGH;
          cnt_nxt   = HIGH_LOAD;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          state_nxt = LOW;
          cnt_nxt   = LOW_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The info register only moves on a pulse-issuing accept, so it stays stable through HIGH and LOW.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      o_msi_info <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) rr_ptr     <= rr_ptr_nxt;
      if (issue)  o_msi_info <= win_info;
    end
  end

  assign o_msi_info_vld = (state == HIGH);
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_imsic_msi_tx_arb.sv
// Scoreboard bench for imsic_msi_tx_arb: expected pulse infos are queued as requests are driven
// and checked by a monitor as pulses appear; a second instance covers NR_REQ=1, HIGH/LOW=1.
module tb_imsic_msi_tx_arb;

  localparam int W = 17;

  logic           clk = 1'b0;
  logic           rstn;
  logic [1:0]     req_vld;
  logic [2*W-1:0] req_info;
  logic [1:0]     req_rdy;
  logic [W-1:0]   o_msi_info;
  logic           o_msi_info_vld;
  logic           busy;

  logic [0:0]     req_vld2;
  logic [W-1:0]   req_info2;
  logic [0:0]     req_rdy2;
  logic [W-1:0]   info2;
  logic           vld2;
  logic           busy2;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  imsic_msi_tx_arb dut (
    .clk(clk), .rstn(rstn), .req_vld(req_vld), .req_info(req_info), .req_rdy(req_rdy),
    .o_msi_info(o_msi_info), .o_msi_info_vld(o_msi_info_vld), .busy(busy)
  );

  imsic_msi_tx_arb #(.NR_REQ(1), .HIGH_CYCLES(1), .LOW_CYCLES(1)) dut2 (
    .clk(clk), .rstn(rstn), .req_vld(req_vld2), .req_info(req_info2), .req_rdy(req_rdy2),
    .o_msi_info(info2), .o_msi_info_vld(vld2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] vld, input logic [W-1:0] i0, input logic [W-1:0] i1);
    @(posedge clk);
    #1;
    req_vld  = vld;
    req_info = {i1, i0};
  endtask

  task automatic wait_grant(output int n, output logic [1:0] g);
    bit done = 0;
    n = 0;
    g = '0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (req_rdy != 2'b00) begin
        g = req_rdy;
        done = 1;
      end else begin
        n++;
      end
    end
    if (!done) checkOutput("grant_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) checkOutput("idle_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Pulse monitor: info and start latency at the rising edge, high/low lengths, info stability while low.
  initial begin
    int cyc = 0, high_cnt = 0, low_cnt = 0, accept_cyc = 0;
    logic prev_vld = 1'b0, prev_busy = 1'b0;
    logic [W-1:0] held_info = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        prev_vld  = 1'b0;
        prev_busy = 1'b0;
        high_cnt  = 0;
        low_cnt   = 0;
      end else begin
        if ((req_rdy & req_vld) != 2'b00) accept_cyc = cyc;
        if (o_msi_info_vld && !prev_vld) begin
          if (exp_q.size() == 0) checkOutput("unexpected_pulse", 1, 0);
          else                   checkOutput("pulse_info", o_msi_info, exp_q.pop_front());
          checkOutput("vld_start", cyc, accept_cyc + 1);
          held_info = o_msi_info;
          high_cnt  = 0;
          low_cnt   = 0;
        end
        if (o_msi_info_vld) high_cnt++;
        if (!o_msi_info_vld && prev_vld) checkOutput("high_len", high_cnt, 4);
        if (busy && !o_msi_info_vld) begin
          low_cnt++;
          checkOutput("info_stable", o_msi_info, held_info);
        end
        if (!busy && prev_busy) checkOutput("low_len", low_cnt, 4);
        prev_vld  = o_msi_info_vld;
        prev_busy = busy;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [1:0] g, exp_g;
    logic [W-1:0] cap;

    rstn = 1'b0; req_vld = '0; req_info = '0; req_vld2 = '0; req_info2 = '0;
    #2;
    checkOutput("rst_vld", o_msi_info_vld, 0);
    checkOutput("rst_info", o_msi_info, 0);
    checkOutput("rst_busy", busy, 0);
    req_vld = 2'b11;
    #1;
    checkOutput("rst_rdy", req_rdy, 0);
    req_vld = 2'b00;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    $display("[TB] single request");
    applyStimulus(2'b01, 17'h00005, '0);
    exp_q.push_back(17'h00005);
    wait_grant(n, g);
    checkOutput("single_rdy", g, 2'b01);
    checkOutput("single_lat", n, 0);
    applyStimulus(2'b01, 17'h00006, '0);
    exp_q.push_back(17'h00006);
    wait_grant(n, g);
    checkOutput("next_accept_gap", n, 8);
    checkOutput("next_accept_rdy", g, 2'b01);
    applyStimulus(2'b00, 17'h00006, '0);
    wait_idle();

    $display("[TB] reset mid-pulse");
    applyStimulus(2'b01, 17'h00007, 17'h00009);
    exp_q.push_back(17'h00007);
    wait_grant(n, g);
    applyStimulus(2'b10, 17'h00007, 17'h00009);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    checkOutput("midrst_vld", o_msi_info_vld, 0);
    checkOutput("midrst_info", o_msi_info, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rdy", req_rdy, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    req_vld = 2'b11;
    req_info = {17'h00014, 17'h00013};
    exp_q.push_back(17'h00013);
    wait_grant(n, g);
    checkOutput("post_reset_grant", g, 2'b01);
    applyStimulus(2'b00, '0, '0);
    wait_idle();

    $display("[TB] contention");
    pulse_reset();
    applyStimulus(2'b11, 17'h00011, 17'h10012);
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_q.push_back(exp_g == 2'b01 ? 17'h00011 : 17'h10012);
      wait_grant(n, g);
      checkOutput("cont_grant", g, exp_g);
      checkOutput("cont_gap", n, (i == 0) ? 0 : 8);
    end
    applyStimulus(2'b00, '0, '0);
    wait_idle();

    $display("[TB] fairness");
    applyStimulus(2'b11, 17'h00021, 17'h00022);
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_q.push_back(exp_g == 2'b01 ? 17'h00021 : 17'h00022);
      wait_grant(n, g);
      checkOutput("fair_grant", g, exp_g);
      @(posedge clk);
      #1;
      if (g == 2'b01) req_vld[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 req_vld[0] = 1'b1;
    end
    applyStimulus(2'b00, '0, '0);
    wait_idle();

    $display("[TB] withdrawn request");
    applyStimulus(2'b01, 17'h00015, 17'h0001f);
    exp_q.push_back(17'h00015);
    wait_grant(n, g);
    checkOutput("drop_first", g, 2'b01);
    applyStimulus(2'b11, 17'h00016, 17'h0001f);
    exp_q.push_back(17'h00016);
    applyStimulus(2'b01, 17'h00016, 17'h0001f);
    wait_grant(n, g);
    checkOutput("drop_grant", g, 2'b01);
    checkOutput("drop_gap", n, 7);
    applyStimulus(2'b00, '0, '0);
    wait_idle();

    $display("[TB] zero setipnum");
    pulse_reset();
    applyStimulus(2'b11, 17'h18000, 17'h00009);
`ifndef IMSIC_MSI_TX_DROP_ZERO_EN
    exp_q.push_back(17'h18000);
`endif
    exp_q.push_back(17'h00009);
    wait_grant(n, g);
    checkOutput("zero_first", g, 2'b01);
    applyStimulus(2'b10, 17'h18000, 17'h00009);
    wait_grant(n, g);
    checkOutput("zero_second", g, 2'b10);
`ifdef IMSIC_MSI_TX_DROP_ZERO_EN
    checkOutput("zero_gap", n, 0);
`else
    checkOutput("zero_gap", n, 8);
`endif
    applyStimulus(2'b00, '0, '0);
    wait_idle();

    $display("[TB] single source, HIGH/LOW = 1");
    cap = '0;
    @(posedge clk);
    #1;
    req_vld2  = 1'b1;
    req_info2 = 17'h00021;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checkOutput("ss_rdy", req_rdy2, (k % 3 == 0) ? 1 : 0);
      checkOutput("ss_vld", vld2, (k % 3 == 1) ? 1 : 0);
      checkOutput("ss_busy", busy2, (k % 3 != 0) ? 1 : 0);
      if (k % 3 == 0) cap = req_info2;
      else            checkOutput("ss_info", info2, cap);
      @(posedge clk);
      #1 req_info2 = W'((k + 2) * 32 + 1);
    end
    req_vld2 = 1'b0;

    repeat (2) @(posedge clk);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
